// File: rtl/light_bar_seq.sv
// Thermometer light-bar sequencer: WIDTH lamps fill/drain one lamp per DIV-cycle step.
// Optional ping-pong mode is compiled in when LIGHT_BAR_BOUNCE_EN is defined.
module light_bar_seq #(
  parameter int WIDTH = 3,
  parameter int DIV   = 1,
  parameter int LW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             t,
  input  logic             dir,
  input  logic             hold,
  input  logic             bounce,
  output logic [WIDTH-1:0] q,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty,
  output logic             wrap
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [LW-1:0] LMAX  = LW'(WIDTH);
  localparam logic [LW-1:0] LMAX1 = LW'(WIDTH - 1);
  localparam logic [PW-1:0] PCMAX = PW'(DIV - 1);

  logic [LW-1:0] lvl_q, lvl_d;
  logic [PW-1:0] pc_q, pc_d;
  logic          dir_q, dir_d;
  logic          wrap_q, wrap_d;
  logic          step;

`ifndef LIGHT_BAR_BOUNCE_EN
  // Without bounce the registered direction is never consulted.
  logic unused_in;
  assign unused_in = bounce ^ dir_q;
`endif

  always_comb begin
    lvl_d  = lvl_q;
    pc_d   = pc_q;
    dir_d  = dir_q;
    wrap_d = 1'b0;
    step   = 1'b0;
    if (!hold) begin
`ifdef LIGHT_BAR_BOUNCE_EN
      if (!bounce) dir_d = dir;
`else
      dir_d = dir;
`endif
      if (t) begin
        if (pc_q == PCMAX) begin
          pc_d = '0;
          step = 1'b1;
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
    end

    if (step) begin
`ifdef LIGHT_BAR_BOUNCE_EN
      if (bounce) begin
        // Ping-pong: reversals reflect off the ends instead of wrapping.
        if (!dir_q) begin
          if (lvl_q == LMAX) begin
            lvl_d  = LMAX1;
            dir_d  = 1'b1;
            wrap_d = 1'b1;
          end else begin
            lvl_d = lvl_q + 1'b1;
          end
        end else begin
          if (lvl_q == '0) begin
            lvl_d  = LW'(1);
            dir_d  = 1'b0;
            wrap_d = 1'b1;
          end else begin
            lvl_d = lvl_q - 1'b1;
          end
        end
      end else
`endif
      begin
        if (!dir) begin
          if (lvl_q == LMAX) begin
            lvl_d  = '0;
            wrap_d = 1'b1;
          end else begin
            lvl_d = lvl_q + 1'b1;
          end
        end else begin
          if (lvl_q == '0) begin
            lvl_d  = LMAX;
            wrap_d = 1'b1;
          end else begin
            lvl_d = lvl_q - 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lvl_q  <= '0;
      pc_q   <= '0;
      dir_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      lvl_q  <= lvl_d;
      pc_q   <= pc_d;
      dir_q  <= dir_d;
      wrap_q <= wrap_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lamp
    assign q[i] = (32'(lvl_q) > 32'(i));
  end

  assign level = lvl_q;
  assign full  = (lvl_q == LMAX);
  assign empty = (lvl_q == '0);
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_light_bar_seq.sv
// Directed bench for light_bar_seq: vector table on a 3-lamp bar plus prescaler,
// bounce and full/empty sequences on other parameterisations sharing one stimulus bus.
module tb_light_bar_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, t = 1'b0, dir = 1'b0, hold = 1'b0, bounce = 1'b0;

  logic [2:0] q3;  logic [1:0] l3; logic f3, e3, w3;
  logic [3:0] qa;  logic [2:0] la; logic fa, ea, wa;
  logic [3:0] qb;  logic [2:0] lb; logic fb, eb, wb;
  logic [4:0] q5;  logic [2:0] l5; logic f5, e5, w5;

  light_bar_seq #(.WIDTH(3), .DIV(1)) u3 (.clk(clk), .reset(reset), .t(t), .dir(dir), .hold(hold),
    .bounce(bounce), .q(q3), .level(l3), .full(f3), .empty(e3), .wrap(w3));
  light_bar_seq #(.WIDTH(4), .DIV(4)) ua (.clk(clk), .reset(reset), .t(t), .dir(dir), .hold(hold),
    .bounce(bounce), .q(qa), .level(la), .full(fa), .empty(ea), .wrap(wa));
  light_bar_seq #(.WIDTH(4), .DIV(1)) ub (.clk(clk), .reset(reset), .t(t), .dir(dir), .hold(hold),
    .bounce(bounce), .q(qb), .level(lb), .full(fb), .empty(eb), .wrap(wb));
  light_bar_seq #(.WIDTH(5), .DIV(1)) u5 (.clk(clk), .reset(reset), .t(t), .dir(dir), .hold(hold),
    .bounce(bounce), .q(q5), .level(l5), .full(f5), .empty(e5), .wrap(w5));

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic tt, input logic d, input logic h, input logic b);
    reset = r; t = tt; dir = d; hold = h; bounce = b;
  endtask

  typedef struct {
    logic       r, tt, d, h;
    logic [2:0] q;
    logic       w;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  initial begin
    // r  t  d  h   q     w
    tbl[0]  = '{1, 0, 0, 0, 3'b000, 0};
    tbl[1]  = '{0, 1, 0, 0, 3'b001, 0};
    tbl[2]  = '{0, 1, 0, 0, 3'b011, 0};
    tbl[3]  = '{0, 1, 0, 0, 3'b111, 0};
    tbl[4]  = '{0, 1, 0, 0, 3'b000, 1};
    tbl[5]  = '{0, 1, 0, 0, 3'b001, 0};
    tbl[6]  = '{1, 1, 1, 0, 3'b000, 0};
    tbl[7]  = '{0, 1, 1, 0, 3'b111, 1};
    tbl[8]  = '{0, 1, 1, 0, 3'b011, 0};
    tbl[9]  = '{0, 1, 1, 0, 3'b001, 0};
    tbl[10] = '{0, 1, 1, 0, 3'b000, 0};
    tbl[11] = '{0, 1, 1, 0, 3'b111, 1};
    tbl[12] = '{0, 1, 1, 1, 3'b111, 0};  // hold at a wrap point: no step, no pulse
    tbl[13] = '{0, 0, 0, 0, 3'b111, 0};
    tbl[14] = '{1, 0, 0, 0, 3'b000, 0};
    tbl[15] = '{0, 1, 0, 0, 3'b001, 0};
    tbl[16] = '{0, 1, 0, 0, 3'b011, 0};
    tbl[17] = '{1, 1, 0, 1, 3'b000, 0};  // reset beats hold mid-run
    tbl[18] = '{0, 1, 0, 0, 3'b001, 0};
    tbl[19] = '{0, 0, 0, 0, 3'b001, 0};

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].r, tbl[i].tt, tbl[i].d, tbl[i].h, 1'b0);
      tick();
      chk($sformatf("v%0d_q", i), int'(q3), int'(tbl[i].q));
      chk($sformatf("v%0d_wrap", i), int'(w3), int'(tbl[i].w));
      chk($sformatf("v%0d_level", i), int'(l3), $countones(tbl[i].q));
      chk($sformatf("v%0d_full", i), int'(f3), int'(tbl[i].q == 3'b111));
      chk($sformatf("v%0d_empty", i), int'(e3), int'(tbl[i].q == 3'b000));
    end

    // Prescaler: one step per 4 edges.
    drive(1, 0, 0, 0, 0); tick();
    chk("pre_rst_level", int'(la), 0);
    chk("pre_rst_empty", int'(ea), 1);
    drive(0, 1, 0, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("pre_e%0d", k), int'(la), k / 4);
    end

    // Suspension via t=0, then via hold=1, at pc=2: step arrives 2 edges late.
    for (int mode = 0; mode < 2; mode++) begin
      drive(1, 0, 0, 0, 0); tick();
      drive(0, 1, 0, 0, 0);
      for (int k = 1; k <= 8; k++) begin
        if (k == 3 || k == 4) drive(0, (mode == 0) ? 1'b0 : 1'b1, 0, (mode == 1) ? 1'b1 : 1'b0, 0);
        else drive(0, 1, 0, 0, 0);
        tick();
        chk($sformatf("susp%0d_e%0d", mode, k), int'(la), (k >= 6) ? 1 : 0);
        chk($sformatf("susp%0d_w%0d", mode, k), int'(wa), 0);
      end
    end

    // Bounce stimulus on WIDTH=4, DIV=1.
    begin
      int exp_l [10];
      int exp_w [10];
`ifdef LIGHT_BAR_BOUNCE_EN
      exp_l = '{1, 2, 3, 4, 3, 2, 1, 0, 1, 2};
      exp_w = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
`else
      exp_l = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
      exp_w = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`endif
      drive(1, 0, 0, 0, 1); tick();
      chk("bnc_rst", int'(lb), 0);
      drive(0, 1, 0, 0, 1);
      for (int k = 0; k < 10; k++) begin
        tick();
        chk($sformatf("bnc_l%0d", k), int'(lb), exp_l[k]);
        chk($sformatf("bnc_w%0d", k), int'(wb), exp_w[k]);
        chk($sformatf("bnc_q%0d", k), int'(qb), (1 << exp_l[k]) - 1);
      end
    end

    // Full/empty on WIDTH=5 across a down-wrap.
    drive(1, 0, 1, 0, 0); tick();
    chk("fe_rst_empty", int'(e5), 1);
    chk("fe_rst_full", int'(f5), 0);
    drive(0, 1, 1, 0, 0);
    for (int k = 0; k < 7; k++) begin
      int el;
      el = (k == 6) ? 5 : 5 - k;
      tick();
      chk($sformatf("fe_l%0d", k), int'(l5), el);
      chk($sformatf("fe_f%0d", k), int'(f5), int'(el == 5));
      chk($sformatf("fe_e%0d", k), int'(e5), int'(el == 0));
      chk($sformatf("fe_w%0d", k), int'(w5), int'(el == 5));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
